muldiv_hilo_ctrl: RTL and testbench

- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO; owns the architectural HI/LO registers.
- Sits beside execute. Decode marks these ops as writing no GPR; execute hands them here.
- Decode reads hi/lo for MFHI/MFLO and stalls on busy.
- One operation in flight; flush cancels it without touching HI/LO.

---
 rtl/muldiv_hilo_ctrl_pkg.sv | 96 +++++++++
 rtl/muldiv_hilo_ctrl_div_iter_step.sv | 33 +++
 rtl/muldiv_hilo_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
// Holds the muldiv op encoding, FSM state codes and decode helpers.
package muldiv_hilo_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MADD  = 4'd5,
        MD_MADDU = 4'd6,
        MD_MSUB  = 4'd7,
        MD_MSUBU = 4'd8,
        MD_MTHI  = 4'd9,
        MD_MTLO  = 4'd10
    } muldiv_op_t;

    typedef logic [1:0] muldiv_state_t;

    localparam muldiv_state_t ST_IDLE = 2'd0;
    localparam muldiv_state_t ST_MUL  = 2'd1;
    localparam muldiv_state_t ST_DIV  = 2'd2;
    localparam muldiv_state_t ST_FIX  = 2'd3;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } acc_mode_t;

    localparam logic [5:0] OPC_SPECIAL  = 6'h00;
    localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_MADD  = 6'h00;
    localparam logic [5:0] FN_MADDU = 6'h01;
    localparam logic [5:0] FN_MSUB  = 6'h04;
    localparam logic [5:0] FN_MSUBU = 6'h05;

    // Decode-side mapping from instruction opcode/funct to a muldiv op.
    function automatic muldiv_op_t muldiv_decode(
        input logic [5:0] opcode,
        input logic [5:0] funct
    );
        muldiv_op_t md;
        logic sp;
        logic sp2;
        sp  = (opcode == OPC_SPECIAL);
        sp2 = (opcode == OPC_SPECIAL2);
        md  = MD_NONE;
        unique case (1'b1)
            sp  && funct == FN_MULT:  md = MD_MULT;
            sp  && funct == FN_MULTU: md = MD_MULTU;
            sp  && funct == FN_DIV:   md = MD_DIV;
            sp  && funct == FN_DIVU:  md = MD_DIVU;
            sp  && funct == FN_MTHI:  md = MD_MTHI;
            sp  && funct == FN_MTLO:  md = MD_MTLO;
            sp2 && funct == FN_MADD:  md = MD_MADD;
            sp2 && funct == FN_MADDU: md = MD_MADDU;
            sp2 && funct == FN_MSUB:  md = MD_MSUB;
            sp2 && funct == FN_MSUBU: md = MD_MSUBU;
            default:                  md = MD_NONE;
        endcase
        return md;
    endfunction

    function automatic logic is_mul_class(input muldiv_op_t op);
        return op inside {MD_MULT, MD_MULTU, MD_MADD,
                          MD_MADDU, MD_MSUB, MD_MSUBU};
    endfunction

    function automatic logic is_div_class(input muldiv_op_t op);
        return op inside {MD_DIV, MD_DIVU};
    endfunction

    function automatic logic is_signed_op(input muldiv_op_t op);
        return op inside {MD_MULT, MD_MADD, MD_MSUB, MD_DIV};
    endfunction

    function automatic acc_mode_t acc_mode(input muldiv_op_t op);
        acc_mode_t m;
        case (op)
            MD_MADD, MD_MADDU: m = ACC_ADD;
            MD_MSUB, MD_MSUBU: m = ACC_SUB;
            default:           m = ACC_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_div_iter_step.sv
// One restoring-division step: shift in the next dividend bit, trial
// subtract. Ports: rem/quo/divisor in, rem_next/quo_next out.
module div_iter_step (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] quo_next
);

    logic [32:0] trial;
    logic [32:0] diff;
    logic        fits;

    // quo carries the unconsumed dividend bits in its top end and
    // collects quotient bits at the bottom as they shift out.
    assign trial = {rem, quo[31]};
    assign diff  = trial - {1'b0, divisor};

    // With rem < divisor, trial < 2*divisor, so bit 32 of the
    // difference is exactly the borrow.
    assign fits = ~diff[32];

    always_comb begin
        rem_next = trial[31:0];
        quo_next = {quo[30:0], 1'b0};
        if (fits) begin
            rem_next = diff[31:0];
            quo_next = {quo[30:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/DIV/MADD/MSUB/MTHI/MTLO sequencer owning HI/LO.
// Ports: req_* handshake in, flush, busy/done status, hi/lo out.
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  muldiv_op_t  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    muldiv_state_t state;
    logic [4:0]    cnt;
    logic          accept;
    logic          mul_last;

    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    acc_mode_t          mul_acc;
    logic [63:0]        prod;
    logic [63:0]        mul_result;
    logic [63:0]        hilo_next;

    logic [31:0] div_rem;
    logic [31:0] div_quo;
    logic [31:0] div_dsr;
    logic [31:0] a_orig;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic [31:0] step_rem;
    logic [31:0] step_quo;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic        a_neg;
    logic        b_neg;

    assign req_ready = (state == ST_IDLE);
    assign busy      = ~req_ready;
    assign accept    = req_valid & req_ready & ~flush;
    assign mul_last  = (state == ST_MUL) && (cnt == 5'd0);

    // A flush or reset in the final cycle discards the result.
    assign done = (mul_last || state == ST_FIX) & ~flush & ~reset;

    // Operands are sign- or zero-extended to 33 bits so a single
    // signed multiply serves both signed and unsigned variants.
    assign prod = 64'(mul_a) * 64'(mul_b);

    if (MUL_LAT > 1) begin : g_mul_pipe
        logic [63:0] pipe [MUL_LAT-1];
        always_ff @(posedge clk) begin
            pipe[0] <= prod;
            for (int i = 1; i < MUL_LAT - 1; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
        assign mul_result = pipe[MUL_LAT-2];
    end else begin : g_mul_comb
        assign mul_result = prod;
    end

    // HI/LO cannot change while busy, so accumulating here is safe.
    always_comb begin
        case (mul_acc)
            ACC_ADD: hilo_next = {hi, lo} + mul_result;
            ACC_SUB: hilo_next = {hi, lo} - mul_result;
            default: hilo_next = mul_result;
        endcase
    end

    div_iter_step u_step (
        .rem      (div_rem),
        .quo      (div_quo),
        .divisor  (div_dsr),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        a_neg = (req_op == MD_DIV) & req_a[31];
        b_neg = (req_op == MD_DIV) & req_b[31];
    end

    assign quo_fix = neg_q ? (~div_quo + 32'd1) : div_quo;
    assign rem_fix = neg_r ? (~div_rem + 32'd1) : div_rem;

    always_ff @(posedge clk) begin
        if (accept && is_mul_class(req_op)) begin
            if (is_signed_op(req_op)) begin
                mul_a <= {req_a[31], req_a};
                mul_b <= {req_b[31], req_b};
            end else begin
                mul_a <= {1'b0, req_a};
                mul_b <= {1'b0, req_b};
            end
            mul_acc <= acc_mode(req_op);
        end
        if (accept && is_div_class(req_op)) begin
            div_rem  <= 32'd0;
            div_quo  <= a_neg ? (~req_a + 32'd1) : req_a;
            div_dsr  <= b_neg ? (~req_b + 32'd1) : req_b;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (req_b == 32'd0);
            a_orig   <= req_a;
        end else if (state == ST_DIV) begin
            div_rem <= step_rem;
            div_quo <= step_quo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 5'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            is_mul_class(req_op): begin
                                state <= ST_MUL;
                                cnt   <= 5'(MUL_LAT - 1);
                            end
                            is_div_class(req_op): begin
                                state <= ST_DIV;
                                cnt   <= 5'd31;
                            end
                            req_op == MD_MTHI: hi <= req_a;
                            req_op == MD_MTLO: lo <= req_a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt == 5'd0) begin
                        {hi, lo} <= hilo_next;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                ST_DIV: begin
                    if (cnt == 5'd0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                ST_FIX: begin
                    // Divide by zero leaves the raw dividend in HI.
                    if (div_zero) begin
                        lo <= 32'hFFFF_FFFF;
                        hi <= a_orig;
                    end else begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl.
// Scoreboard queue of expected HI/LO results per issued op.
module tb_muldiv_hilo_ctrl;
    import muldiv_hilo_ctrl_pkg::*;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    muldiv_op_t  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_ready;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    muldiv_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_model(
        input muldiv_op_t  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [63:0] hl
    );
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ps;
        logic [63:0]        pu;
        logic [31:0]        q;
        logic [31:0]        r;
        sa = $signed(a);
        sb = $signed(b);
        ps = sa * sb;
        pu = {32'd0, a} * {32'd0, b};
        case (op)
            MD_MULT:  return ps;
            MD_MULTU: return pu;
            MD_MADD:  return hl + ps;
            MD_MADDU: return hl + pu;
            MD_MSUB:  return hl - ps;
            MD_MSUBU: return hl - pu;
            MD_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            MD_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: return hl;
        endcase
    endfunction

    // Called just after a falling edge; returns just after the
    // falling edge following the HI/LO write.
    task automatic do_op(
        input muldiv_op_t  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] e_hi,
        input logic [31:0] e_lo,
        input string       nm
    );
        int   n;
        bit   seen;
        exp_t e;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before got %b want 1", nm, req_ready);
        end
        exp_q.push_back('{e_hi, e_lo,
                          is_div_class(op) ? DIV_LAT : MUL_LAT});
        m_hi      = e_hi;
        m_lo      = e_lo;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = MD_NONE;
        n    = 1;
        seen = 0;
        while (!seen && n <= 64) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cyc %0d got %b want 1", nm, n, busy);
            end
            if (done === 1'b1) seen = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (!seen || n != e.lat) begin
            errors++;
            $display("FAIL %s latency got %0d (seen %0d) want %0d",
                     nm, n, seen, e.lat);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_in_done got %b want 0", nm, req_ready);
        end
        @(negedge clk);
        checks++;
        if (hi !== e.hi || lo !== e.lo) begin
            errors++;
            $display("FAIL %s hilo got %h_%h want %h_%h",
                     nm, hi, lo, e.hi, e.lo);
        end
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after busy %b ready %b done %b want 0 1 0",
                     nm, busy, req_ready, done);
        end
    endtask

    task automatic do_mt(
        input muldiv_op_t  op,
        input logic [31:0] a,
        input string       nm
    );
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = 32'd0;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = MD_NONE;
        if (op == MD_MTHI) m_hi = a;
        else               m_lo = a;
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL %s hilo got %h_%h want %h_%h",
                     nm, hi, lo, m_hi, m_lo);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s status busy %b done %b want 0 0", nm, busy, done);
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = MD_NONE;
        req_a     = 32'd0;
        req_b     = 32'd0;
        flush     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status ready %b busy %b done %b want 1 0 0",
                     req_ready, busy, done);
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_hilo got %h_%h want 0_0", hi, lo);
        end
    endtask

    task automatic test_mult;
        do_op(MD_MULT,  32'hFFFF_FFFF, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2,
              32'h0000_0001, 32'hFFFF_FFFE, "multu");
    endtask

    task automatic test_div;
        do_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");
        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    endtask

    task automatic test_mt_acc;
        do_mt(MD_MTLO, 32'hFFFF_FFFF, "mtlo");
        do_mt(MD_MTHI, 32'd0, "mthi");
        do_op(MD_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, "maddu");
        do_op(MD_MSUB, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, "msub");
    endtask

    task automatic test_flush;
        bit saw_done;
        req_valid = 1'b1;
        req_op    = MD_DIV;
        req_a     = 32'd50;
        req_b     = 32'd5;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = MD_NONE;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL flush_div done got %b want 0", done);
        end
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_div idle busy %b ready %b want 0 1",
                     busy, req_ready);
        end
        saw_done = 0;
        repeat (40) begin
            if (done === 1'b1) saw_done = 1;
            @(negedge clk);
        end
        checks++;
        if (saw_done || hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL flush_div hilo got %h_%h done %b want %h_%h 0",
                     hi, lo, saw_done, m_hi, m_lo);
        end
        req_valid = 1'b1;
        req_op    = MD_MTHI;
        req_a     = 32'hA5A5_5A5A;
        flush     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = MD_NONE;
        flush     = 1'b0;
        checks++;
        if (hi !== m_hi || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_mthi hi got %h busy %b want %h 0",
                     hi, busy, m_hi);
        end
        req_valid = 1'b1;
        req_op    = MD_MULT;
        req_a     = 32'd3;
        req_b     = 32'd3;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = MD_NONE;
        repeat (MUL_LAT - 1) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL flush_done pre got %b want 1", done);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL flush_done masked got %b want 0", done);
        end
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_done hilo got %h_%h busy %b want %h_%h 0",
                     hi, lo, busy, m_hi, m_lo);
        end
    endtask

    task automatic test_div_zero;
        do_op(MD_DIVU, 32'h0000_1234, 32'd0,
              32'h0000_1234, 32'hFFFF_FFFF, "divu_by0");
        do_op(MD_DIV, 32'hFFFF_FF00, 32'd0,
              32'hFFFF_FF00, 32'hFFFF_FFFF, "div_neg_by0");
        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'd0, 32'h8000_0000, "div_ovf");
    endtask

    task automatic test_back_to_back;
        do_op(MD_MULTU, 32'd5, 32'd7, 32'd0, 32'd35, "b2b_mul");
        do_op(MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, "b2b_div");
        do_op(MD_MADD, 32'hFFFF_FFFF, 32'd4,
              32'd0, 32'hFFFF_FFFF, "b2b_madd");
    endtask

    task automatic test_random;
        muldiv_op_t  ops [8];
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] r;
        ops = '{MD_MULT, MD_MULTU, MD_MADD, MD_MADDU,
                MD_MSUB, MD_MSUBU, MD_DIV, MD_DIVU};
        for (int i = 0; i < 16; i++) begin
            op = ops[$urandom_range(0, 7)];
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (i[0]) b = b >> $urandom_range(0, 31);
            r  = ref_model(op, a, b, {m_hi, m_lo});
            do_op(op, a, b, r[63:32], r[31:0], "random");
        end
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        do_mt(MD_MTHI, 32'h1111_2222, "pre_mthi");
        do_mt(MD_MTLO, 32'h3333_4444, "pre_mtlo");
        req_valid = 1'b1;
        req_op    = MD_DIV;
        req_a     = 32'd1000;
        req_b     = 32'd3;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = MD_NONE;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid done got %b want 0", done);
        end
        @(negedge clk);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid state got %h_%h ready %b want 0_0 1",
                     hi, lo, req_ready);
        end
        saw_done = 0;
        repeat (20) begin
            if (done === 1'b1) saw_done = 1;
            @(negedge clk);
        end
        checks++;
        if (saw_done || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid after done %b busy %b want 0 0",
                     saw_done, busy);
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_mt_acc;
        test_flush;
        test_div_zero;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
